hv_ngram_bundler: RTL and testbench

//  Streaming temporal n-gram encoder for the HV encoder datapath; generalises the

---
 rtl/hv_ngram_bundler_if.sv | 28 ++
 rtl/hv_ngram_bundler.sv | 149 ++++++++++++++
 tb/tb_hv_ngram_bundler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/hv_ngram_bundler_if.sv
// Stream bundle for hv_ngram_bundler.
//   in_*  : item HV stream into the bundler (in_hv, in_last, in_valid, in_ready)
//   out_* : binarised bundle stream out of the bundler (out_hv, out_ncnt, out_valid, out_ready)
// The master modport is the producer of items and the consumer of bundles;
// the slave modport is the bundler itself.
interface hv_ngram_bundler_if #(
  parameter int HVDimension = 512,
  parameter int NCntWidth   = 16
);
  logic [HVDimension-1:0] in_hv;
  logic                   in_last;
  logic                   in_valid;
  logic                   in_ready;
  logic [HVDimension-1:0] out_hv;
  logic [NCntWidth-1:0]   out_ncnt;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output in_hv, in_last, in_valid, out_ready,
    input  in_ready, out_hv, out_ncnt, out_valid
  );

  modport slave (
    input  in_hv, in_last, in_valid, out_ready,
    output in_ready, out_hv, out_ncnt, out_valid
  );
endinterface

// File: rtl/hv_ngram_bundler.sv
// Streaming temporal n-gram encoder.
// Items are kept in a sliding window (win[0] newest). Every accepted item forms
// an n-gram g = item ^ rho^1(win[0]) ^ ... ^ rho^(N-1)(win[N-2]), rho = rotate left,
// once enough items are present. N-grams are added into saturating per-bit
// bipolar counters; on the last item the sign of each counter is emitted.
// Ports:
//   clk_i        clock
//   rst_i        asynchronous reset, active high
//   clr_i        synchronous clear of window, counters, size latch and FSM
//   ngram_size_i n-gram size, sampled on the first item of a sequence
//   bus          item input stream and bundle output stream (slave side)
module hv_ngram_bundler #(
  parameter int HVDimension  = 512,
  parameter int MaxNGram     = 4,
  parameter int CounterWidth = 8,
  parameter int NCntWidth    = 16,
  parameter int NSizeWidth   = $clog2(MaxNGram + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic [NSizeWidth-1:0] ngram_size_i,
  hv_ngram_bundler_if.slave     bus
);

  // Only MaxNGram-1 past items ever feed an n-gram; keep one slot when MaxNGram=1.
  localparam int WinDepth = (MaxNGram > 1) ? MaxNGram - 1 : 1;

  localparam logic [CounterWidth-1:0] CntMax = {1'b0, {(CounterWidth-1){1'b1}}};
  localparam logic [CounterWidth-1:0] CntMin = {1'b1, {(CounterWidth-1){1'b0}}};
  localparam logic [CounterWidth-1:0] CntOne = CounterWidth'(1);
  localparam logic [NSizeWidth-1:0]   FillMax = NSizeWidth'(MaxNGram);

  typedef enum logic {ACC, OUT} state_t;

  state_t                  state;
  logic [HVDimension-1:0]  win [WinDepth];
  logic [NSizeWidth-1:0]   fill;
  logic [NSizeWidth-1:0]   n_lat;
  logic [CounterWidth-1:0] cnt [HVDimension];
  logic [NCntWidth-1:0]    ncnt;
  logic [HVDimension-1:0]  out_hv_q;
  logic [NCntWidth-1:0]    out_ncnt_q;

  logic                    accept;
  logic                    flush;
  logic [NSizeWidth-1:0]   n_eff;
  logic                    g_valid;
  logic [HVDimension-1:0]  g;
  logic [CounterWidth-1:0] cnt_next [HVDimension];
  logic [NCntWidth-1:0]    ncnt_next;
  logic [HVDimension-1:0]  bin;

  function automatic logic [NSizeWidth-1:0] clamp_size(input logic [NSizeWidth-1:0] s);
    if (s == '0)    return NSizeWidth'(1);
    if (s > FillMax) return FillMax;
    return s;
  endfunction

  function automatic logic [HVDimension-1:0] rotl(input logic [HVDimension-1:0] x,
                                                  input int k);
    return (x << k) | (x >> (HVDimension - k));
  endfunction

  assign accept = bus.in_valid && (state == ACC);
  // Clearing the datapath happens on clr_i and when a bundle leaves.
  assign flush  = clr_i || ((state == OUT) && bus.out_ready);
  // The first item of a sequence uses the live size input; later items the latch.
  assign n_eff  = (fill == '0) ? clamp_size(ngram_size_i) : n_lat;
  assign g_valid = ({1'b0, fill} + 1'b1) >= {1'b0, n_eff};

  always_comb begin
    // NOTE: every comb output gets a default before any condition, so no latch is inferred.
    g = bus.in_hv;
    for (int k = 1; k < MaxNGram; k++) begin
      if (NSizeWidth'(k) < n_eff) g = g ^ rotl(win[k-1], k);
    end
  end

  always_comb begin
    bin = '0;
    for (int i = 0; i < HVDimension; i++) begin
      cnt_next[i] = cnt[i];
      if (g_valid) begin
        if (g[i]) begin
          if (cnt[i] != CntMax) cnt_next[i] = cnt[i] + CntOne;
        end else if (cnt[i] != CntMin) begin
          cnt_next[i] = cnt[i] - CntOne;
        end
      end
      // Strictly positive: sign bit clear and non-zero; a tie yields 0.
      bin[i] = !cnt_next[i][CounterWidth-1] && (cnt_next[i] != '0);
    end
    ncnt_next = (g_valid && (ncnt != '1)) ? ncnt + 1'b1 : ncnt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ACC;
      fill       <= '0;
      n_lat      <= '0;
      ncnt       <= '0;
      out_hv_q   <= '0;
      out_ncnt_q <= '0;
      // NOTE: the window and counters are reset as well, because a bundle must never
      // start from stale counts after reset.
      for (int k = 0; k < WinDepth; k++) win[k] <= '0;
      for (int i = 0; i < HVDimension; i++) cnt[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
      if (flush) begin
        fill  <= '0;
        n_lat <= '0;
        ncnt  <= '0;
        for (int k = 0; k < WinDepth; k++) win[k] <= '0;
        for (int i = 0; i < HVDimension; i++) cnt[i] <= '0;
      end else if (accept) begin
        for (int k = WinDepth - 1; k > 0; k--) win[k] <= win[k-1];
        win[0] <= bus.in_hv;
        if (fill != FillMax) fill <= fill + 1'b1;
        if (fill == '0) n_lat <= n_eff;
        ncnt <= ncnt_next;
        for (int i = 0; i < HVDimension; i++) cnt[i] <= cnt_next[i];
      end

      if (clr_i) begin
        state      <= ACC;
        out_hv_q   <= '0;
        out_ncnt_q <= '0;
      end else begin
        case (state)
          ACC: if (accept && bus.in_last) begin
            out_hv_q   <= bin;
            out_ncnt_q <= ncnt_next;
            state      <= OUT;
          end
          OUT: if (bus.out_ready) state <= ACC;
          default: state <= ACC;
        endcase
      end
    end
  end

  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = (state == OUT);
  assign bus.out_hv    = out_hv_q;
  assign bus.out_ncnt  = out_ncnt_q;

endmodule

// File: tb/tb_hv_ngram_bundler.sv
// Directed bench for hv_ngram_bundler. Two instances share one stimulus:
// dut_a uses CounterWidth=8, dut_b uses CounterWidth=3, so saturation shows
// up as a difference between them on the long run of identical items.
module tb_hv_ngram_bundler;

  localparam int H  = 8;
  localparam int MN = 4;
  localparam int NC = 16;
  localparam int SW = $clog2(MN + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic [SW-1:0] ngram_size = '0;
  logic [H-1:0]  in_hv = '0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hv_ngram_bundler_if #(.HVDimension(H), .NCntWidth(NC)) bus_a ();
  hv_ngram_bundler_if #(.HVDimension(H), .NCntWidth(NC)) bus_b ();

  assign bus_a.in_hv = in_hv;  assign bus_a.in_last = in_last;
  assign bus_a.in_valid = in_valid;  assign bus_a.out_ready = out_ready;
  assign bus_b.in_hv = in_hv;  assign bus_b.in_last = in_last;
  assign bus_b.in_valid = in_valid;  assign bus_b.out_ready = out_ready;

  hv_ngram_bundler #(.HVDimension(H), .MaxNGram(MN), .CounterWidth(8), .NCntWidth(NC)) dut_a (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .ngram_size_i(ngram_size), .bus(bus_a.slave));

  hv_ngram_bundler #(.HVDimension(H), .MaxNGram(MN), .CounterWidth(3), .NCntWidth(NC)) dut_b (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .ngram_size_i(ngram_size), .bus(bus_b.slave));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic check_out(input string tag, input logic [31:0] valid, input logic [31:0] ready,
                           input logic [31:0] hv_a, input logic [31:0] hv_b,
                           input logic [31:0] ncnt);
    check({tag, ".a.valid"}, 32'(bus_a.out_valid), valid);
    check({tag, ".a.ready"}, 32'(bus_a.in_ready),  ready);
    check({tag, ".a.hv"},    32'(bus_a.out_hv),    hv_a);
    check({tag, ".a.ncnt"},  32'(bus_a.out_ncnt),  ncnt);
    check({tag, ".b.valid"}, 32'(bus_b.out_valid), valid);
    check({tag, ".b.hv"},    32'(bus_b.out_hv),    hv_b);
    check({tag, ".b.ncnt"},  32'(bus_b.out_ncnt),  ncnt);
  endtask

  task automatic send(input logic [H-1:0] hv, input logic last);
    in_hv = hv; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".drain.valid"}, 32'(bus_a.out_valid), 32'd0);
    check({tag, ".drain.ready"}, 32'(bus_a.in_ready),  32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_out("reset_async", 0, 1, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    check_out("reset", 0, 1, 0, 0, 0);

    // 1: N=1, three F0 -> F0, ncnt 3, valid one cycle after the last accept.
    ngram_size = 3'd1;
    send(8'hF0, 1'b0);
    send(8'hF0, 1'b0);
    check("t1.not_yet_valid", 32'(bus_a.out_valid), 32'd0);
    send(8'hF0, 1'b1);
    check_out("t1", 1, 0, 8'hF0, 8'hF0, 3);
    drain("t1");

    // 2: N=2, 01 then 03 -> g = 03 ^ 02 = 01, ncnt 1.
    ngram_size = 3'd2;
    send(8'h01, 1'b0);
    send(8'h03, 1'b1);
    check_out("t2", 1, 0, 8'h01, 8'h01, 1);
    drain("t2");

    // 3a: N=1, FF then 00 -> all ties -> 00, ncnt 2.
    ngram_size = 3'd1;
    send(8'hFF, 1'b0);
    send(8'h00, 1'b1);
    check_out("t3a", 1, 0, 8'h00, 8'h00, 2);
    drain("t3a");

    // 3b: N=3 with only two items -> nothing bundled.
    ngram_size = 3'd3;
    send(8'h5A, 1'b0);
    send(8'h3C, 1'b1);
    check_out("t3b", 1, 0, 8'h00, 8'h00, 0);
    drain("t3b");

    // 4: N=1, 5x FF then 4x 00. W=8: +1 -> FF. W=3: sat +3 then -1 -> 00.
    ngram_size = 3'd1;
    for (int i = 0; i < 5; i++) send(8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) send(8'h00, i == 3);
    check_out("t4", 1, 0, 8'hFF, 8'h00, 9);
    drain("t4");

    // 5: N=2, 0F then F0 -> g = F0 ^ 1E = EE. Hold output under backpressure.
    ngram_size = 3'd2;
    send(8'h0F, 1'b0);
    send(8'hF0, 1'b1);
    in_hv = 8'hFF; in_last = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check_out($sformatf("t5.hold%0d", c), 1, 0, 8'hEE, 8'hEE, 1);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    drain("t5");
    // A single item with N=2 must not combine with the previous sequence.
    send(8'h55, 1'b1);
    check_out("t5.fresh", 1, 0, 8'h00, 8'h00, 0);
    drain("t5.fresh");

    // Size change mid-sequence is ignored: N=1 latched, 0F + 33 -> 03, ncnt 2.
    ngram_size = 3'd1;
    send(8'h0F, 1'b0);
    ngram_size = 3'd4;
    send(8'h33, 1'b1);
    check_out("size_hold", 1, 0, 8'h03, 8'h03, 2);
    drain("size_hold");

    // Size above MaxNGram clamps to 4: three items give no n-gram.
    ngram_size = 3'd7;
    send(8'h81, 1'b0);
    send(8'h42, 1'b0);
    send(8'h24, 1'b1);
    check_out("clamp", 1, 0, 8'h00, 8'h00, 0);
    drain("clamp");

    // Leave a non-zero bundle on the outputs before the reset test.
    ngram_size = 3'd1;
    send(8'hC3, 1'b1);
    check_out("pre_rst", 1, 0, 8'hC3, 8'hC3, 1);

    // 6a: async reset mid-sequence (also mid-OUT for outputs).
    drain("pre_rst");
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    #1 rst = 1'b1;
    #1 check_out("t6.rst", 0, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ngram_size = 3'd1;
    send(8'hAA, 1'b1);
    check_out("t6.rst.after", 1, 0, 8'hAA, 8'hAA, 1);

    // 6b: clr mid-sequence, with a last item offered in the same cycle.
    drain("t6.rst.after");
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    clr = 1'b1; in_hv = 8'hFF; in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check_out("t6.clr", 0, 1, 0, 0, 0);
    send(8'hAA, 1'b1);
    check_out("t6.clr.after", 1, 0, 8'hAA, 8'hAA, 1);
    drain("t6.clr.after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
